pwm_bank: RTL
=============

Name: pwm_bank

Overview:
- Parametrised multi-channel PWM generator. Replaces the fixed-duty fan_pwm and LED divider logic in the top level.
- Per-channel duty, enable and polarity come from software-written regfile registers.
- Period and prescale are shared by all channels.
- Configuration is double-buffered and only applied at a period boundary, so outputs never glitch.
- An optional per-period duty ramp gives soft-start and soft-stop (fan, LED fade).

Parameters:
NCH, 4, number of PWM channels
CW, 16, width of period counter, duty and ramp step
PW, 16, width of prescaler

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  asynchronous active-low reset
cfg_prescale  in  PW  clocks per count tick = cfg_prescale+1
cfg_period  in  CW  counts per PWM period = cfg_period+1
cfg_duty  in  NCH*CW  per-channel target high-count, packed, channel i at [i*CW +: CW]
cfg_step  in  CW  ramp step per period; 0 = no ramp
cfg_enable  in  NCH  per-channel enable
cfg_invert  in  NCH  per-channel output polarity invert
cfg_update  in  1  single-cycle request to load all cfg_* into shadow registers
pwm_out  out  NCH  PWM outputs, registered
period_tick  out  1  one-cycle pulse per completed period
update_done  out  1  one-cycle pulse when a shadow load took effect

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - all shadow registers = 0, duty_act = 0, pending = 0
  - prescaler = 0, cnt = 0
  - pwm_out = 0, period_tick = 0, update_done = 0
- Prescaler:
  - pre counts 0..pre_sh; tick = (pre == pre_sh); pre wraps to 0 on tick.
  - pre_sh = 0 gives a tick every clock.
- Period counter:
  - On tick, cnt increments; at cnt == per_sh it wraps to 0.
  - wrap = tick & (cnt == per_sh).
  - Period length = (per_sh+1)*(pre_sh+1) clocks.
- Update handshake:
  - cfg_update sets pending.
  - In a wrap cycle, load occurs if (pending | cfg_update); pending clears and all shadows (pre, per, duty, step, enable, invert) load from cfg_*.
  - A cfg_update arriving in the same cycle as a wrap is served at that wrap.
  - Repeated cfg_update pulses before a wrap merge into one load; the latest cfg_* values are sampled at the wrap.
  - Because reset shadows are 0, a wrap occurs every clock, so the first update loads on the clock after cfg_update.
- Ramp, evaluated only in wrap cycles, using the post-load duty_sh and step_sh:
  - step_sh == 0: duty_act = duty_sh.
  - step_sh != 0: duty_act moves toward duty_sh by min(step_sh, |duty_sh - duty_act|); no overshoot, no wrap-around.
  - Arithmetic is CW+1 bits wide to avoid overflow.
- Output, registered, one clock after cnt:
  - pwm_out[i] = en_sh[i] ? ((cnt < duty_act[i]) ^ inv_sh[i]) : inv_sh[i]
  - duty_act = 0 gives constant inactive level; duty_act > per_sh gives constant active level.
- period_tick: registered, high for the one cycle after each wrap.
- update_done: registered, high for the one cycle after a wrap that loaded; always coincides with period_tick.
- Changing cfg_* without cfg_update has no effect on outputs.

Test Plan:
- Basic duty:
  - Setup: prescale=0, period=9, duty0=3, enable=0001, update.
  - Required: pwm_out[0] high exactly 3 of every 10 clocks; period_tick every 10 clocks; update_done pulses once.
- Extremes and polarity:
  - Setup: duty1=0, duty2=10, duty3=4 with invert3=1, all enabled, period=9.
  - Required: ch1 constant 0; ch2 constant 1; ch3 low 4 and high 6 clocks per period.
- Prescale and glitch-free update:
  - Setup: prescale=3, period=4 (20-clock period); change duty0 2→4 mid-period with cfg_update.
  - Required: the current period still shows 8 high clocks; the next period shows 16; no short pulses.
- Ramp:
  - Setup: step=2, duty0 0→5, update.
  - Required: duty_act sequence 2,4,5,5 over successive periods.
  - Then set duty0=0, step=3: sequence 2,0.
- Simultaneous events:
  - Setup: cfg_update asserted exactly in a wrap cycle; then two cfg_update pulses within one period.
  - Required: first load occurs at that same wrap; the two pulses produce one update_done, with the cfg values sampled at the wrap.
- Reset mid-operation:
  - Stimulus: deassert axi_aresetn asynchronously while outputs are high.
  - Required: pwm_out=0 immediately; after release, outputs stay 0 until cfg_update and its load.

Source files
------------

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator with a shared prescaler and period.
// Configuration is captured into shadow registers only at a period boundary,
// so a running period always completes with the settings it started with.
// An optional per-period duty ramp gives soft start and soft stop.
module pwm_bank #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int PW  = 16
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic [PW-1:0]     cfg_prescale,
  input  logic [CW-1:0]     cfg_period,
  input  logic [NCH*CW-1:0] cfg_duty,
  input  logic [CW-1:0]     cfg_step,
  input  logic [NCH-1:0]    cfg_enable,
  input  logic [NCH-1:0]    cfg_invert,
  input  logic              cfg_update,
  output logic [NCH-1:0]    pwm_out,
  output logic              period_tick,
  output logic              update_done
);

  // Shared timing state and shadows
  logic [PW-1:0]  pre_reg, pre_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [PW-1:0]  pre_sh_reg;
  logic [CW-1:0]  per_sh_reg;
  logic [CW-1:0]  step_sh_reg;
  logic [NCH-1:0] en_sh_reg;
  logic [NCH-1:0] inv_sh_reg;
  logic           pending_reg, pending_next;
  logic [NCH-1:0] pwm_next;
  logic           period_tick_reg;
  logic           update_done_reg;

  logic           tick;
  logic           wrap;
  logic           load;
  logic [CW-1:0]  step_eff;

  // Prescaler tick, period wrap and the load decision for this cycle
  always_comb begin
    tick         = (pre_reg == pre_sh_reg);
    wrap         = tick && (cnt_reg == per_sh_reg);
    load         = wrap && (pending_reg || cfg_update);
    pre_next     = tick ? '0 : pre_reg + 1'b1;
    cnt_next     = wrap ? '0 : (tick ? cnt_reg + 1'b1 : cnt_reg);
    pending_next = load ? 1'b0 : (pending_reg || cfg_update);
    // The ramp at a loading wrap already uses the freshly loaded step
    step_eff     = load ? cfg_step : step_sh_reg;
  end

  // Counters, pending flag, shared shadows and registered status outputs
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      pre_reg         <= '0;
      cnt_reg         <= '0;
      pending_reg     <= 1'b0;
      pre_sh_reg      <= '0;
      per_sh_reg      <= '0;
      step_sh_reg     <= '0;
      en_sh_reg       <= '0;
      inv_sh_reg      <= '0;
      period_tick_reg <= 1'b0;
      update_done_reg <= 1'b0;
    end else begin
      pre_reg         <= pre_next;
      cnt_reg         <= cnt_next;
      pending_reg     <= pending_next;
      period_tick_reg <= wrap;
      update_done_reg <= load;
      if (load) begin
        pre_sh_reg  <= cfg_prescale;
        per_sh_reg  <= cfg_period;
        step_sh_reg <= cfg_step;
        en_sh_reg   <= cfg_enable;
        inv_sh_reg  <= cfg_invert;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CW-1:0] duty_sh_reg;
      logic [CW-1:0] duty_act_reg, duty_act_next;
      logic [CW-1:0] duty_tgt;
      logic [CW:0]   diff_up, diff_dn, step_w, sum_up, sum_dn;

      // Ramp duty_act toward the (post-load) target, clamped at the target
      always_comb begin
        duty_tgt = load ? cfg_duty[gi*CW +: CW] : duty_sh_reg;
        step_w   = {1'b0, step_eff};
        diff_up  = {1'b0, duty_tgt} - {1'b0, duty_act_reg};
        diff_dn  = {1'b0, duty_act_reg} - {1'b0, duty_tgt};
        sum_up   = {1'b0, duty_act_reg} + step_w;
        sum_dn   = {1'b0, duty_act_reg} - step_w;
        duty_act_next = duty_act_reg;
        if (wrap) begin
          if (step_eff == '0) begin
            duty_act_next = duty_tgt;
          end else if (duty_tgt > duty_act_reg) begin
            duty_act_next = (diff_up > step_w) ? sum_up[CW-1:0] : duty_tgt;
          end else if (duty_tgt < duty_act_reg) begin
            duty_act_next = (diff_dn > step_w) ? sum_dn[CW-1:0] : duty_tgt;
          end else begin
            duty_act_next = duty_tgt;
          end
        end
      end

      // Per-channel duty shadow and active (ramped) duty
      always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
          duty_sh_reg  <= '0;
          duty_act_reg <= '0;
        end else begin
          duty_act_reg <= duty_act_next;
          if (load) begin
            duty_sh_reg <= cfg_duty[gi*CW +: CW];
          end
        end
      end

      assign pwm_next[gi] = en_sh_reg[gi] ?
                            ((cnt_reg < duty_act_reg) ^ inv_sh_reg[gi]) :
                            inv_sh_reg[gi];
    end
  endgenerate

  // Output register: compare result for the current count, one clock later
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      pwm_out <= '0;
    end else begin
      pwm_out <= pwm_next;
    end
  end

  assign period_tick = period_tick_reg;
  assign update_done = update_done_reg;

endmodule
